// File: rtl/apply_phase_sched_if.sv
// rtl/apply_phase_sched_if.sv - read, compare and write-back handshake bundle for apply_phase_sched
interface apply_phase_sched_if #(
  parameter int DATA_W = 64,
  parameter int VID_W  = 32
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [VID_W-1:0]  rd_req_vid;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_rsp_a;
  logic [DATA_W-1:0] rd_rsp_b;

  logic              cmp_valid_o;
  logic              cmp_ready_i;
  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic              cmp_rsp_valid;
  logic              cmp_rsp_ready;
  logic [DATA_W-1:0] cmp_rsp_data;
  logic              cmp_rsp_flag;

  logic              wr_valid;
  logic              wr_ready;
  logic [VID_W-1:0]  wr_vid;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_req_valid, rd_req_vid,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b,
    output cmp_valid_o, cmp_a, cmp_b, cmp_rsp_ready,
    input  cmp_ready_i, cmp_rsp_valid, cmp_rsp_data, cmp_rsp_flag,
    output wr_valid, wr_vid, wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_vid,
    output rd_req_ready, rd_rsp_valid, rd_rsp_a, rd_rsp_b,
    input  cmp_valid_o, cmp_a, cmp_b, cmp_rsp_ready,
    output cmp_ready_i, cmp_rsp_valid, cmp_rsp_data, cmp_rsp_flag,
    input  wr_valid, wr_vid, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/apply_phase_sched.sv
// rtl/apply_phase_sched.sv - apply-phase vertex sequencer: read, compare, conditional write-back
// Optional busy-cycle counter output enabled by SCHED_CYCLE_CNT_EN.
module apply_phase_sched #(
  parameter int DATA_W = 64,
  parameter int VID_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VID_W-1:0] vid_base,
  input  logic [VID_W-1:0] vid_count,
  output logic             busy,
  output logic             done,
  output logic [VID_W-1:0] update_cnt,
  output logic             converged,
`ifdef SCHED_CYCLE_CNT_EN
  output logic [31:0]      cycle_cnt,
`endif
  apply_phase_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_RD, ISSUE, WAIT_CMP, WRITE, NEXT, FIN
  } state_t;

  state_t           state;
  logic [VID_W-1:0] vid;
  logic [VID_W-1:0] remain;

  assign bus.rd_req_vid = vid;
  assign bus.wr_vid     = vid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      vid               <= '0;
      remain            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      update_cnt        <= '0;
      converged         <= 1'b0;
      bus.rd_req_valid  <= 1'b0;
      bus.cmp_valid_o   <= 1'b0;
      bus.cmp_a         <= {DATA_W{1'b0}};
      bus.cmp_b         <= {DATA_W{1'b0}};
      bus.cmp_rsp_ready <= 1'b0;
      bus.wr_valid      <= 1'b0;
      bus.wr_data       <= {DATA_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vid        <= vid_base;
            remain     <= vid_count;
            update_cnt <= '0;
            busy       <= 1'b1;
            if (vid_count == '0) begin
              state <= FIN;
            end else begin
              state            <= REQ;
              bus.rd_req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.rd_req_ready) begin
            bus.rd_req_valid <= 1'b0;
            state            <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (bus.rd_rsp_valid) begin
            bus.cmp_a       <= bus.rd_rsp_a;
            bus.cmp_b       <= bus.rd_rsp_b;
            bus.cmp_valid_o <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cmp_ready_i) begin
            bus.cmp_valid_o   <= 1'b0;
            bus.cmp_rsp_ready <= 1'b1;
            state             <= WAIT_CMP;
          end
        end
        WAIT_CMP: begin
          if (bus.cmp_rsp_valid) begin
            bus.cmp_rsp_ready <= 1'b0;
            bus.wr_data       <= bus.cmp_rsp_data;
            if (bus.cmp_rsp_flag) begin
              bus.wr_valid <= 1'b1;
              state        <= WRITE;
            end else begin
              state <= NEXT;
            end
          end
        end
        WRITE: begin
          if (bus.wr_ready) begin
            bus.wr_valid <= 1'b0;
            update_cnt   <= update_cnt + 1'b1;
            state        <= NEXT;
          end
        end
        NEXT: begin
          vid    <= vid + 1'b1;
          remain <= remain - 1'b1;
          if (remain == VID_W'(1)) begin
            state <= FIN;
          end else begin
            state            <= REQ;
            bus.rd_req_valid <= 1'b1;
          end
        end
        FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          converged <= (update_cnt == '0);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_CYCLE_CNT_EN
  // The FIN cycle is the hand-back cycle and is not counted as vertex work.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy && state != FIN && cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule
